// File: rtl/core_shifter_iter.sv
// core_shifter_iter: iterative handshaked barrel shifter (ARM shifter-operand
// semantics for LSL/LSR/ASR/ROR/RRX with carry-out). Shifts at most STEP bit
// positions per cycle, so a W-bit shift takes ceil(e/STEP) SHIFT cycles.
//
// Ports:
//   clk, rst          clock, async active-high reset
//   kill              abort any in-flight op, back to IDLE next edge
//   in_valid/in_ready request handshake; op, base, shift, c_in request fields
//   out_valid/out_ready result handshake; q, c result and carry-out
//   busy              high while in SHIFT or DONE
module core_shifter_iter #(
  parameter int W    = 32,
  parameter int STEP = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         kill,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic [W-1:0] base,
  input  logic [7:0]   shift,
  input  logic         c_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] q,
  output logic         c,
  output logic         busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [2:0] OP_LSL = 3'd0;
  localparam logic [2:0] OP_LSR = 3'd1;
  localparam logic [2:0] OP_ASR = 3'd2;
  localparam logic [2:0] OP_ROR = 3'd3;
  localparam logic [2:0] OP_RRX = 3'd4;

  localparam int         W1     = W + 1;
  localparam logic [7:0] C_STEP = 8'(STEP);
  localparam logic [7:0] C_W    = 8'(W);
  localparam logic [7:0] C_W1   = 8'(W + 1);

  logic [1:0]   r_state;
  logic [2:0]   r_op;
  logic         r_fill;     // sign bit of the latched base, ASR fill
  logic [W-1:0] r_q;        // working register
  logic         r_c;
  logic [7:0]   r_e;        // remaining shift count
  logic [W-1:0] r_qo;       // result register, only updated on entry to DONE
  logic         r_co;

  logic         w_acc;
  logic         w_load;
  logic [7:0]   w_e0;
  logic         w_c0;
  logic [7:0]   w_s;
  logic [W-1:0] w_sq;
  logic         w_sc;
  logic [1:0]   w_nstate;
  logic [7:0]   w_e_nxt;
  logic [W-1:0] w_q_nxt;
  logic         w_c_nxt;

  assign in_ready  = ~rst & ~kill &
                     ((r_state == S_IDLE) | ((r_state == S_DONE) & out_ready));
  assign w_acc     = in_valid & in_ready;
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign q         = r_qo;
  assign c         = r_co;

  // Initial count and carry for a newly accepted op. LSL/LSR saturate at W+1
  // (everything shifted out, carry cleared); ASR saturates at W.
  always_comb begin
    w_e0 = 8'd0;
    w_c0 = c_in;
    case (op)
      OP_LSL, OP_LSR: w_e0 = (shift > C_W1) ? C_W1 : shift;
      OP_ASR:         w_e0 = (shift > C_W)  ? C_W  : shift;
      OP_ROR: begin
        w_e0 = shift & (C_W - 8'd1);
        // A whole number of rotations: value unchanged, carry is the msb.
        if ((shift != 8'd0) && (w_e0 == 8'd0)) w_c0 = base[W-1];
      end
      OP_RRX:  w_e0 = 8'd1;
      default: w_e0 = 8'd0;
    endcase
  end

  // One SHIFT-cycle step of s = min(STEP, e) positions.
  always_comb begin
    w_s  = (r_e > C_STEP) ? C_STEP : r_e;
    w_sq = r_q;
    w_sc = r_c;
    case (r_op)
      OP_LSL: {w_sc, w_sq} = {r_c, r_q} << w_s;
      OP_LSR: {w_sq, w_sc} = {r_q, r_c} >> w_s;
      OP_ASR: {w_sq, w_sc} = W1'({{STEP{r_fill}}, r_q, r_c} >> w_s);
      OP_ROR: begin
        w_sq = W'({r_q, r_q} >> w_s);
        w_sc = w_sq[W-1];
      end
      OP_RRX: begin
        w_sq = {r_c, r_q[W-1:1]};
        w_sc = r_q[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    w_nstate = r_state;
    w_e_nxt  = r_e;
    w_q_nxt  = r_q;
    w_c_nxt  = r_c;
    w_load   = 1'b0;
    case (r_state)
      S_IDLE: if (w_acc) w_load = 1'b1;
      S_SHIFT: begin
        w_q_nxt = w_sq;
        w_c_nxt = w_sc;
        w_e_nxt = r_e - w_s;
        if (w_e_nxt == 8'd0) w_nstate = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          if (w_acc) w_load   = 1'b1;   // back-to-back accept
          else       w_nstate = S_IDLE;
        end
      end
      default: w_nstate = S_IDLE;
    endcase
    if (w_load) begin
      w_q_nxt  = base;
      w_c_nxt  = w_c0;
      w_e_nxt  = w_e0;
      w_nstate = (w_e0 == 8'd0) ? S_DONE : S_SHIFT;
    end
    if (kill) w_nstate = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_op    <= 3'd0;
      r_fill  <= 1'b0;
      r_q     <= '0;
      r_c     <= 1'b0;
      r_e     <= 8'd0;
      r_qo    <= '0;
      r_co    <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_q     <= w_q_nxt;
      r_c     <= w_c_nxt;
      r_e     <= w_e_nxt;
      if (w_load) begin
        r_op   <= op;
        r_fill <= base[W-1];
      end
      // Publish the result only on entry to DONE (including a back-to-back
      // zero-count op that goes DONE -> DONE), so q/c never show partials.
      if ((w_nstate == S_DONE) && ((r_state != S_DONE) || w_load)) begin
        r_qo <= w_q_nxt;
        r_co <= w_c_nxt;
      end
    end
  end

endmodule

// File: tb/tb_core_shifter_iter.sv
module tb_core_shifter_iter;

  localparam int W    = 32;
  localparam int STEP = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         kill = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] base = '0;
  logic [7:0]   shift = 8'd0;
  logic         c_in = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] q;
  logic         c;
  logic         busy;

  core_shifter_iter #(.W(W), .STEP(STEP)) dut (
    .clk(clk), .rst(rst), .kill(kill), .in_valid(in_valid),
    .in_ready(in_ready), .op(op), .base(base), .shift(shift), .c_in(c_in),
    .out_valid(out_valid), .out_ready(out_ready), .q(q), .c(c), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] base;
    logic [7:0]  sh;
    logic        cin;
    logic [31:0] eq;
    logic        ec;
    int          lat;
  } vec_t;

  vec_t tv[16];

  // Counts negedges from the accept edge until out_valid; bounded.
  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 20);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    @(negedge clk);
    in_valid = 1'b1; op = v.op; base = v.base; shift = v.sh; c_in = v.cin;
    out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_valid(lat);
    chk($sformatf("vec%0d_lat", idx), 64'(lat), 64'(v.lat));
    chk($sformatf("vec%0d_q", idx), 64'(q), 64'(v.eq));
    chk($sformatf("vec%0d_c", idx), 64'(c), 64'(v.ec));
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk($sformatf("vec%0d_drop", idx), 64'(out_valid), 64'd0);
  endtask

  initial begin
    int lat;
    int seen;
    tv[0]  = '{3'd0, 32'h8000_0001, 8'd33,  1'b1, 32'h0000_0000, 1'b0, 6};
    tv[1]  = '{3'd0, 32'h8000_0001, 8'd32,  1'b1, 32'h0000_0000, 1'b1, 5};
    tv[2]  = '{3'd2, 32'h8000_0000, 8'd200, 1'b0, 32'hFFFF_FFFF, 1'b1, 5};
    tv[3]  = '{3'd3, 32'h1234_5678, 8'd64,  1'b1, 32'h1234_5678, 1'b0, 1};
    tv[4]  = '{3'd3, 32'h1234_5678, 8'd4,   1'b0, 32'h8123_4567, 1'b1, 2};
    tv[5]  = '{3'd4, 32'h0000_0003, 8'd0,   1'b1, 32'h8000_0001, 1'b1, 2};
    tv[6]  = '{3'd6, 32'hDEAD_BEEF, 8'd17,  1'b1, 32'hDEAD_BEEF, 1'b1, 1};
    tv[7]  = '{3'd1, 32'h8000_0000, 8'd32,  1'b0, 32'h0000_0000, 1'b1, 5};
    tv[8]  = '{3'd1, 32'hF0F0_F0F0, 8'd4,   1'b1, 32'h0F0F_0F0F, 1'b0, 2};
    tv[9]  = '{3'd0, 32'h0000_000F, 8'd0,   1'b1, 32'h0000_000F, 1'b1, 1};
    tv[10] = '{3'd2, 32'h7FFF_FFFF, 8'd40,  1'b1, 32'h0000_0000, 1'b0, 5};
    tv[11] = '{3'd0, 32'h1234_5678, 8'd9,   1'b1, 32'h68AC_F000, 1'b0, 3};
    tv[12] = '{3'd2, 32'h8000_0010, 8'd4,   1'b1, 32'hF800_0001, 1'b0, 2};
    tv[13] = '{3'd1, 32'h0000_0001, 8'd33,  1'b1, 32'h0000_0000, 1'b0, 6};
    tv[14] = '{3'd3, 32'h0000_0001, 8'd1,   1'b0, 32'h8000_0000, 1'b1, 2};
    tv[15] = '{3'd3, 32'h0000_0005, 8'd0,   1'b1, 32'h0000_0005, 1'b1, 1};

    // Reset state
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_q", 64'(q), 64'd0);
    chk("rst_c", 64'(c), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 16; i++) run_vec(tv[i], i);

    // Back-to-back: LSR #0 then LSR #9 with in_valid and out_ready held.
    @(negedge clk);
    in_valid = 1'b1; op = 3'd1; base = 32'h1234_5678; shift = 8'd0;
    c_in = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 shift = 8'd9; c_in = 1'b0;
    @(negedge clk);
    chk("b2b_first_valid", 64'(out_valid), 64'd1);
    chk("b2b_first_q", 64'(q), 64'h1234_5678);
    chk("b2b_first_c", 64'(c), 64'd1);
    chk("b2b_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_valid(lat);
    chk("b2b_second_lat", 64'(lat), 64'd3);
    chk("b2b_second_q", 64'(q), 64'h0009_1A2B);
    chk("b2b_second_c", 64'(c), 64'd0);
    @(negedge clk);
    out_ready = 1'b0;
    chk("b2b_idle", 64'(busy), 64'd0);

    // kill during SHIFT of LSL #20
    @(negedge clk);
    in_valid = 1'b1; op = 3'd0; base = 32'h0000_00FF; shift = 8'd20;
    c_in = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("kill_busy_before", 64'(busy), 64'd1);
    kill = 1'b1;
    #1 chk("kill_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 kill = 1'b0;
    chk("kill_idle", 64'(busy), 64'd0);
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("kill_no_valid", 64'(seen), 64'd0);

    // Async reset mid-SHIFT clears result registers immediately.
    @(negedge clk);
    in_valid = 1'b1; op = 3'd2; base = 32'h8000_0000; shift = 8'd200;
    c_in = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_q", 64'(q), 64'd0);
    chk("arst_c", 64'(c), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Result held stable while out_ready is low in DONE.
    @(negedge clk);
    in_valid = 1'b1; op = 3'd3; base = 32'h1234_5678; shift = 8'd4;
    c_in = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_valid(lat);
    chk("hold_lat", 64'(lat), 64'd2);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("hold%0d_valid", k), 64'(out_valid), 64'd1);
      chk($sformatf("hold%0d_q", k), 64'(q), 64'h8123_4567);
      chk($sformatf("hold%0d_c", k), 64'(c), 64'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("hold_release", 64'(out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
